// File: rtl/rv32_pkg.sv
// rv32_pkg: definitions shared by the RV32 front end (fetch, decode, imm_gen).
// Build option: INST_FETCH_MISALIGN_EN adds the ERR fetch state for misaligned targets.
package rv32_pkg;

    localparam logic [6:0]  OPC_OP_IMM    = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [31:0] RV32_NOP_INST = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
    localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3
`ifdef INST_FETCH_MISALIGN_EN
        ,
        ERR  = 3'd4
`endif
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// pc_reg: program counter flop with redirect load and sequential +4 increment.
// Build option: INST_FETCH_MISALIGN_EN keeps load targets unmodified; otherwise
// the two low bits of a loaded target are forced to zero.
module pc_reg
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV32_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] load_target;

`ifdef INST_FETCH_MISALIGN_EN
    // Misaligned targets never reach this point; the fetch FSM diverts them to ERR.
    assign load_target = load_pc;
`else
    assign load_target = load_pc & 32'hFFFF_FFFC;
`endif

    // Redirect load has priority over the sequential increment; +4 wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_target;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. One outstanding imem request at a time,
// a single-entry instruction buffer towards decode, and kill of in-flight
// responses when a redirect arrives before the response.
// Build option: INST_FETCH_MISALIGN_EN enables the ERR state and misalign_err.
module inst_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV32_RESET_PC,
    parameter logic [31:0] NOP_INST = RV32_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    fetch_state_e state_reg;
    fetch_state_e state_next;
    logic         kill_reg;
    logic         kill_next;
    logic         pc_load;
    logic         pc_inc;
    logic         capture;
    logic         release_inst;
    logic         take_redirect;
    logic [31:0]  pc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .inc     (pc_inc),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    assign imem_req  = (state_reg == REQ);
    assign imem_addr = pc;

`ifdef INST_FETCH_MISALIGN_EN
    assign misalign_err = (state_reg == ERR);
`else
    assign misalign_err = 1'b0;
`endif

    // State register and kill flag for the single outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            kill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
        end
    end

    // Next state, kill tracking and PC update requests.
    always_comb begin
        state_next    = state_reg;
        kill_next     = kill_reg;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        capture       = 1'b0;
        release_inst  = 1'b0;
        take_redirect = 1'b0;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                state_next = WAIT;
                // The request goes out this cycle with the old PC, so its response must die.
                if (redirect_valid) begin
                    kill_next     = 1'b1;
                    take_redirect = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    kill_next = 1'b0;
                    if (redirect_valid || kill_reg) begin
                        state_next = REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                    take_redirect = redirect_valid;
                end else if (redirect_valid) begin
                    kill_next     = 1'b1;
                    take_redirect = 1'b1;
                end
            end
            HOLD: begin
                // Without inst_ready a redirect is ignored: it belongs to the held instruction.
                if (inst_ready) begin
                    release_inst = 1'b1;
                    state_next   = REQ;
                    if (redirect_valid) begin
                        take_redirect = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
`ifdef INST_FETCH_MISALIGN_EN
            ERR: begin
                if (imem_rvalid) begin
                    kill_next = 1'b0;
                end
                take_redirect = redirect_valid;
            end
`endif
            default: state_next = IDLE;
        endcase

        if (take_redirect) begin
`ifdef INST_FETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_next = ERR;
            end else begin
                pc_load = 1'b1;
                // Leaving ERR with a stale response still due: let WAIT swallow it
                // before the next request so only one request is ever outstanding.
                if (state_reg == ERR) begin
                    state_next = (kill_reg && !imem_rvalid) ? WAIT : REQ;
                end
            end
`else
            pc_load = 1'b1;
`endif
        end
    end

    // Instruction buffer presented to decode; NOP while nothing valid is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
        end else if (capture) begin
            inst_valid <= 1'b1;
            inst       <= imem_rdata;
            inst_pc    <= pc;
        end else if (release_inst) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus a randomized run of inst_fetch against
// an instruction-stream reference model and a variable-latency memory model.
// Build option: INST_FETCH_MISALIGN_EN selects the misaligned-target expectations.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // memory model state: one pending request with a countdown
    logic        pend = 1'b0;
    int          cnt = 0;
    int          lat = 1;
    logic [31:0] paddr = 32'h0;

    inst_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock: memory records this cycle's request, then responds after lat cycles.
    task automatic tick();
        if (imem_req === 1'b1) begin
            checks++;
            if (pend) begin
                errors++;
                $display("FAIL req_overlap: got second request addr=%h while %h outstanding", imem_addr, paddr);
            end
            pend  = 1'b1;
            cnt   = lat;
            paddr = imem_addr;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(paddr);
                pend        = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0)   begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        checks++; if (inst_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== NOP)          begin errors++; $display("FAIL rst_inst: got %h want %h", inst, NOP); end
        checks++; if (inst_pc !== 32'h0)     begin errors++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", misalign_err); end
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", imem_req); end
        $display("reset: released, state idle");
    endtask

    task automatic test_first_fetch();
        lat = 1;
        tick();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL ff_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ff_addr: got %h want 0", imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ff_early_valid: got %b want 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1)      begin errors++; $display("FAIL ff_valid: got %b want 1", inst_valid); end
        checks++; if (inst !== 32'h0050_0093)   begin errors++; $display("FAIL ff_inst: got %h want 00500093", inst); end
        checks++; if (inst_pc !== 32'h0)        begin errors++; $display("FAIL ff_pc: got %h want 0", inst_pc); end
        $display("first_fetch: inst=%h pc=%h", inst, inst_pc);
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'h0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v=%b inst=%h pc=%h req=%b want v=1 inst=00500093 pc=0 req=0",
                         inst_valid, inst, inst_pc, imem_req);
            end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_next: got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL stall_release: got v=%b inst=%h want v=0 inst=%h", inst_valid, inst, NOP); end
        $display("stall: consumed after 5 cycles, next addr=%h", imem_addr);
    endtask

    task automatic test_redirect_wait();
        lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (imem_rvalid !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_resp: got rvalid=%b v=%b want rvalid=1 v=0", imem_rvalid, inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got v=%b inst=%h want v=0", inst_valid, inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_req: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
        lat = 1;
        tick();
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== memf(32'h100)) begin
            errors++;
            $display("FAIL rw_fetch: got v=%b pc=%h inst=%h want v=1 pc=100 inst=%h", inst_valid, inst_pc, inst, memf(32'h100));
        end
        $display("redirect_wait: inst=%h pc=%h", inst, inst_pc);
    endtask

    task automatic test_wrap();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_hold: got v=%b pc=%h want v=1 pc=fffffffc", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        tick();
        tick();
        checks++; if (inst_pc !== 32'h0 || inst !== 32'h0050_0093) begin errors++; $display("FAIL wrap_fetch: got pc=%h inst=%h want pc=0 inst=00500093", inst_pc, inst); end
        $display("wrap: fffffffc -> %h", inst_pc);
    endtask

    task automatic test_misalign();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
`ifdef INST_FETCH_MISALIGN_EN
        checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mis_err: got err=%b req=%b v=%b want 1 0 0", misalign_err, imem_req, inst_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL mis_stay: got err=%b req=%b want err=1 req=0", misalign_err, imem_req); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
`endif
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL mis_req: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin errors++; $display("FAIL mis_fetch: got v=%b pc=%h want v=1 pc=200", inst_valid, inst_pc); end
        $display("misalign: recovered at pc=%h", inst_pc);
    endtask

    task automatic test_reset_wait();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        lat = 3;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rwait_async: got addr=%h req=%b v=%b want 0 0 0", imem_addr, imem_req, inst_valid); end
        tick();
        rst_n = 1'b1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rwait_idle: got req=%b v=%b want 0 0", imem_req, inst_valid); end
        tick();
        checks++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rwait_req: got rvalid=%b req=%b addr=%h want 1 1 0", imem_rvalid, imem_req, imem_addr); end
        lat = 1;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rwait_ignored: got v=%b want 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0050_0093) begin errors++; $display("FAIL rwait_fetch: got v=%b pc=%h inst=%h want 1 0 00500093", inst_valid, inst_pc, inst); end
        $display("reset_wait: late response ignored, pc=%h", inst_pc);
    endtask

    // Reference: exp_pc is the address of the held or next instruction. A consume
    // moves it to pc+4 or the redirect target; a redirect with nothing held retargets it.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        prev_stall;
        int          delivered;
        int          starve;
        rst_n = 1'b0;
        pend = 1'b0;
        imem_rvalid = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_pc     = 32'h0;
        prev_stall = 1'b0;
        delivered  = 0;
        starve     = 0;
        for (int c = 0; c < 2500; c++) begin
            if (prev_stall) begin
                checks++;
                if (inst_valid !== 1'b1) begin errors++; $display("FAIL rnd_stall: got v=%b want 1 at cycle %0d", inst_valid, c); end
            end
            if (inst_valid === 1'b1) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== memf(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_inst: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, exp_pc, memf(exp_pc));
                end
                if (!prev_stall) begin
                    delivered++;
                    starve = 0;
                    $display("rnd deliver: pc=%h inst=%h", inst_pc, inst);
                end
            end else begin
                checks++;
                if (inst !== NOP) begin errors++; $display("FAIL rnd_nop: got %h want %h", inst, NOP); end
            end
            starve++;
            if (starve > 100) begin
                checks++;
                errors++;
                $display("FAIL rnd_progress: got no instruction for %0d cycles, want one within 100", starve);
                break;
            end
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'h0000_1000 + ($urandom_range(0, 255) << 2));
`ifndef INST_FETCH_MISALIGN_EN
            tgt[1:0] = 2'($urandom_range(0, 3));
`endif
            inst_ready     = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = tgt;
            if (inst_valid === 1'b1) begin
                if (inst_ready) exp_pc = redirect_valid ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
            end else if (redirect_valid) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
            end
            prev_stall = (inst_valid === 1'b1) && !inst_ready;
            lat = $urandom_range(1, 4);
            tick();
        end
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (delivered < 100) begin errors++; $display("FAIL rnd_count: got %0d deliveries want >= 100", delivered); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_wrap();
        test_misalign();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end within the time limit");
        $fatal(1, "timeout");
    end

endmodule
